// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver. Synchronizes the asynchronous rx line,
//            qualifies the start bit at half a bit period, samples each data
//            bit at mid-bit (LSB first) and reports the byte with a one-cycle
//            valid strobe, or a one-cycle frame_err strobe if the stop bit is
//            sampled low.
// Ports    : clk        - system clock, rising edge
//            reset      - synchronous, active-high reset
//            rx         - asynchronous serial input, idle high
//            data[7:0]  - last accepted byte, held until the next valid
//            valid      - one-cycle strobe, data updated
//            busy       - high from start detection until back in IDLE
//            frame_err  - one-cycle strobe, stop bit sampled low
//            parity_err - (UART_RX_PARITY_EN only) one-cycle strobe, even
//                         parity check failed
// Options  : `define UART_RX_PARITY_EN to receive 8E1 frames instead of 8N1.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       frame_err
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd4;
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    logic [2:0]             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_frame_err;
    logic                   w_accept;
`ifdef UART_RX_PARITY_EN
    logic                   r_par;
    logic                   r_parity_err;
    logic                   w_par_ok;
`endif

    // Synchronizer presets to the idle level so reset never looks like a start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
    // Even parity: the eight data bits plus the parity bit XOR to zero
    assign w_par_ok = ~(^{r_shift, r_par});
    assign w_accept = w_rx_s & w_par_ok;
`else
    assign w_accept = w_rx_s;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_data       <= 8'h00;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle by default
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                c_ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (!w_rx_s) begin
                        r_state <= c_ST_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                c_ST_START: begin
                    // Line must still be low at mid start bit, else it was a glitch
                    if (r_cnt == c_HALF_M1) begin
                        if (w_rx_s) begin
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= c_ST_DATA;
                            r_cnt     <= '0;
                            r_bit_idx <= 3'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_ST_DATA: begin
                    if (r_cnt == c_LAST) begin
                        r_shift[r_bit_idx] <= w_rx_s;
                        r_cnt              <= '0;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= c_ST_PARITY;
`else
                            r_state <= c_ST_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                c_ST_PARITY: begin
                    if (r_cnt == c_LAST) begin
                        r_par   <= w_rx_s;
                        r_cnt   <= '0;
                        r_state <= c_ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif

                c_ST_STOP: begin
                    // Decide at mid stop bit so a back-to-back start edge is caught
                    if (r_cnt == c_LAST) begin
                        if (w_accept) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end
                        r_frame_err <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= ~w_par_ok;
`endif
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx. Drives serial frames
//            on rx, counts strobes in a negedge monitor and compares against
//            hand-computed expectations. Define UART_RX_PARITY_EN for the
//            8E1 scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    parameter int CPB  = 16;
    localparam int c_SYNC = 2;
    localparam int c_HALF = CPB / 2;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks   = 0;
    int failures = 0;

    // Monitor state
    int         n_valid = 0;
    int         n_ferr  = 0;
    int         n_perr  = 0;
    int         n_both  = 0;
    int         n_wide  = 0;
    int         n_brise = 0;
    int         n_bfall = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ferr  = 1'b0;
    logic       prev_busy  = 1'b0;
    logic [7:0] cap_q[$];

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (c_SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .busy       (busy),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            cap_q.push_back(data);
        end
        if (frame_err) n_ferr++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) n_perr++;
`endif
        if (valid && frame_err) n_both++;
        if ((valid && prev_valid) || (frame_err && prev_ferr)) n_wide++;
        if (busy && !prev_busy) n_brise++;
        if (!busy && prev_busy) n_bfall++;
        prev_valid = valid;
        prev_ferr  = frame_err;
        prev_busy  = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, optional parity bit, stop bit held stop_len clks
    task automatic send_frame(input logic [7:0] b, input logic has_par, input logic par,
                              input logic stop_bit, input int stop_len);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (has_par) begin
            rx = par;
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
    endtask

    logic has_par;
    int   base_v, base_f, base_p, base_r, base_fall;

    initial begin
`ifdef UART_RX_PARITY_EN
        has_par = 1'b1;
`else
        has_par = 1'b0;
`endif
        reset = 1'b1;
        rx    = 1'b0;

        // 1. Reset held with rx low: outputs stay at reset values
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_data", 32'(data), 32'h00);
            check("rst_valid", 32'(valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_ferr", 32'(frame_err), 32'd0);
        end
        reset = 1'b0;
        rx    = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_strobes", 32'(n_valid + n_ferr), 32'd0);

        // 2. 0x55 then 0xAA back to back, good stop bits (even parity bit = 0 for both)
        base_fall = n_bfall;
        send_frame(8'h55, has_par, 1'b0, 1'b1, CPB);
        send_frame(8'hAA, has_par, 1'b0, 1'b1, CPB);
        idle(4);
        check("b2b_valid_cnt", 32'(n_valid), 32'd2);
        check("b2b_first", 32'(cap_q[0]), 32'h55);
        check("b2b_second", 32'(cap_q[1]), 32'hAA);
        check("b2b_data", 32'(data), 32'hAA);
        check("b2b_busy_falls", 32'(n_bfall - base_fall), 32'd2);
        check("b2b_ferr", 32'(n_ferr), 32'd0);
        check("b2b_busy_idle", 32'(busy), 32'd0);

        // 3. Start glitch of CPB/4 clks: busy pulses, no strobes
        base_r = n_brise;
        base_v = n_valid;
        base_f = n_ferr;
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        check("glitch_busy_up", 32'(busy), 32'd1);
        repeat (c_HALF + c_SYNC + 1 - CPB / 4) @(negedge clk);
        check("glitch_busy_down", 32'(busy), 32'd0);
        idle(CPB);
        check("glitch_rise", 32'(n_brise - base_r), 32'd1);
        check("glitch_valid", 32'(n_valid - base_v), 32'd0);
        check("glitch_ferr", 32'(n_ferr - base_f), 32'd0);

        // 4. 0x3C with stop bit low (held past mid-bit, then line idles high)
        base_v = n_valid;
        base_f = n_ferr;
        send_frame(8'h3C, has_par, 1'b0, 1'b0, (3 * CPB) / 4);
        idle(2 * CPB);
        check("ferr_cnt", 32'(n_ferr - base_f), 32'd1);
        check("ferr_valid", 32'(n_valid - base_v), 32'd0);
        check("ferr_data", 32'(data), 32'hAA);
        check("ferr_busy", 32'(busy), 32'd0);

        // 5. Reset inside bit 4 of 0xF0 aborts the frame, then 0x81 is received
        base_v = n_valid;
        base_f = n_ferr;
        rx = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        rx = 1'b1;
        repeat (c_HALF) @(negedge clk);
        check("abort_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", 32'(data), 32'h00);
        idle(5 * CPB);
        check("abort_strobes", 32'((n_valid - base_v) + (n_ferr - base_f)), 32'd0);
        send_frame(8'h81, has_par, 1'b0, 1'b1, CPB);
        idle(4);
        check("after_abort_valid", 32'(n_valid - base_v), 32'd1);
        check("after_abort_data", 32'(data), 32'h81);

`ifdef UART_RX_PARITY_EN
        // 6. 0x07 has three ones: parity bit 1 is good, 0 is bad
        base_v = n_valid;
        base_p = n_perr;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, CPB);
        idle(4);
        check("par_ok_valid", 32'(n_valid - base_v), 32'd1);
        check("par_ok_data", 32'(data), 32'h07);
        check("par_ok_perr", 32'(n_perr - base_p), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, CPB);
        idle(4);
        check("par_bad_perr", 32'(n_perr - base_p), 32'd1);
        check("par_bad_valid", 32'(n_valid - base_v), 32'd1);
        check("par_bad_data", 32'(data), 32'h07);
`else
        base_p = n_perr;
        check("no_parity_strobes", 32'(base_p), 32'd0);
`endif

        // Global strobe properties over the whole run
        check("strobe_exclusive", 32'(n_both), 32'd0);
        check("strobe_width", 32'(n_wide), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver; the receive-side counterpart of the team's uart_tx. It synchronizes the asynchronous rx line, detects the start bit, samples each bit at mid-bit, and delivers one byte per frame with a single-cycle valid strobe. It sits between the board RX pin and SoC peripheral logic, e.g. the uvSensor bridge on the j1_soc bus.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200 baud); must be >= 4.
SYNC_STAGES, 2, flip-flop depth of the rx input synchronizer; must be >= 2.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
rx  in  1  asynchronous serial input; idle high.
data  out  8  last received byte, LSB first on the wire; holds until the next valid.
valid  out  1  one-cycle strobe: data updated and frame accepted.
busy  out  1  high from start-bit detection until return to IDLE.
frame_err  out  1  one-cycle strobe: stop bit sampled low.

Behaviour:
- Reset (sampled on posedge clk, reset=1):
  - state=IDLE; data=8'h00; valid=0; busy=0; frame_err=0.
  - Synchronizer flops preset to 1, so no false start.
  - Bit counter and baud counter cleared.
  - Reset mid-frame aborts the frame; no valid, no frame_err.
- rx_s is the output of the SYNC_STAGES-deep synchronizer. All decisions use rx_s, never rx.
- Baud counter: 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2 (integer floor).
- IDLE:
  - busy=0.
  - On rx_s==0, go to START, clear the counter, set busy=1 on the next cycle.
- START:
  - Count to HALF-1.
  - If rx_s==1 at that point, it is a glitch: return to IDLE, busy=0, no strobes.
  - Otherwise clear the counter, bit index=0, go to DATA.
- DATA:
  - At counter==CLKS_PER_BIT-1, sample rx_s into shift[bit index] (LSB first), clear the counter, increment the index.
  - After index 7 is sampled, go to STOP.
- STOP:
  - At counter==CLKS_PER_BIT-1, sample rx_s.
  - If 1: data<=shift, valid=1 for exactly one cycle.
  - If 0: frame_err=1 for one cycle; data unchanged.
  - Either way go to IDLE next cycle.
- valid and frame_err are never high together, and each is high for exactly one clk.
- Leaving STOP at mid-stop-bit lets a back-to-back frame's start edge be caught; IDLE re-arms the cycle after the strobe.
- Break condition (rx held low): one frame_err, then a new START. The glitch filter fails only when rx returns high, so a stuck-low line produces repeated frame_err, one per frame time.
- Latency: valid asserts SYNC_STAGES + HALF + 9*CLKS_PER_BIT (±1) cycles after the rx falling edge.
- Inputs other than rx are sampled every clk; no handshake from the consumer. An unread byte is overwritten by the next valid frame.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: a parity state between DATA and STOP samples the 9th bit.
  - Adds output parity_err (1 bit, one-cycle strobe, reset 0), asserted with the stop-bit decision when the XOR of the 8 data bits and the parity bit is 1.
  - On parity error: data is not updated and valid stays 0. parity_err and frame_err may assert together.
  - Latency grows by CLKS_PER_BIT.
- Undefined: port parity_err absent, 8N1 only, no parity state.

Test Plan:
(Each scenario runs at CLKS_PER_BIT=16 and the default 434, clk period 20 ns.)
1. reset=1 for 5 clk with rx=0 -> data=8'h00, valid=0, busy=0, frame_err=0 throughout. Release with rx=1 -> stays IDLE.
2. Send 8'h55 then 8'hAA, back to back, with stop bit=1 -> two valid pulses, each 1 clk wide. data=8'h55, then 8'hAA. busy falls between frames. No frame_err.
3. Pulse rx low for CLKS_PER_BIT/4 clk, then high -> busy rises, then falls within HALF+SYNC_STAGES+1 clk. No valid, no frame_err.
4. Send 8'h3C with stop bit=0 -> frame_err pulses 1 clk, valid stays 0, data keeps its prior value (8'hAA).
5. Assert reset at bit 4 of a frame carrying 8'hF0, release, then send 8'h81 -> no strobe for the aborted frame. Next valid carries data=8'h81.
6. With UART_RX_PARITY_EN, send 8'h07 with parity=1 -> valid with data=8'h07. Then 8'h07 with parity=0 -> parity_err=1, valid=0, data stays 8'h07.
